// File: rtl/sat_bin_seq_if.sv
// sat_bin_seq_if: host, clause-memory and engine signals of the bin sequencer
// Modports: master = sequencer side, slave = host / clause memory / sat_engine side.
// Groups: host (start_bin, bin_id, done_bin, sat, unsat, bkt_lvl, timeout),
//         memory (mem_rd_req, mem_rd_valid, mem_wr, mem_addr, mem_bin),
//         engine (eng_wr_carray, eng_rd_carray, eng_wr_var_states, eng_wr_lvl_states,
//                 eng_start_core, eng_base_lvl_en, eng_done_core, eng_sat, eng_unsat, eng_bkt_lvl).
interface sat_bin_seq_if #(
    parameter int NUM_CLAUSES  = 8,
    parameter int NUM_VARS     = 8,
    parameter int NUM_LVLS     = 8,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16
);
    localparam int CW = $clog2(NUM_CLAUSES);
    logic                    start_bin;
    logic [WIDTH_BIN_ID-1:0] bin_id;
    logic                    done_bin;
    logic                    sat;
    logic                    unsat;
    logic [WIDTH_LVL-1:0]    bkt_lvl;
    logic                    timeout;
    logic                    mem_rd_req;
    logic                    mem_rd_valid;
    logic                    mem_wr;
    logic [CW-1:0]           mem_addr;
    logic [WIDTH_BIN_ID-1:0] mem_bin;
    logic [NUM_CLAUSES-1:0]  eng_wr_carray;
    logic [NUM_CLAUSES-1:0]  eng_rd_carray;
    logic [NUM_VARS-1:0]     eng_wr_var_states;
    logic [NUM_LVLS-1:0]     eng_wr_lvl_states;
    logic                    eng_start_core;
    logic                    eng_base_lvl_en;
    logic                    eng_done_core;
    logic                    eng_sat;
    logic                    eng_unsat;
    logic [WIDTH_LVL-1:0]    eng_bkt_lvl;
    modport master (
        input  start_bin, bin_id, mem_rd_valid, eng_done_core, eng_sat, eng_unsat, eng_bkt_lvl,
        output done_bin, sat, unsat, bkt_lvl, timeout, mem_rd_req, mem_wr, mem_addr, mem_bin,
               eng_wr_carray, eng_rd_carray, eng_wr_var_states, eng_wr_lvl_states,
               eng_start_core, eng_base_lvl_en
    );
    modport slave (
        output start_bin, bin_id, mem_rd_valid, eng_done_core, eng_sat, eng_unsat, eng_bkt_lvl,
        input  done_bin, sat, unsat, bkt_lvl, timeout, mem_rd_req, mem_wr, mem_addr, mem_bin,
               eng_wr_carray, eng_rd_carray, eng_wr_var_states, eng_wr_lvl_states,
               eng_start_core, eng_base_lvl_en
    );
endinterface

// File: rtl/sat_bin_seq.sv
// sat_bin_seq: runs one bin through sat_engine (load clauses, start, wait, read back, report)
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (sat_bin_seq_if.master: host handshake, clause memory and engine strobes).
// Optional SEQ_TIMEOUT_EN: RUN watchdog of TIMEOUT_CYCLES (parameter exists only then);
// without it timeout is tied low and RUN waits indefinitely for the engine.
module sat_bin_seq #(
    parameter int NUM_CLAUSES  = 8,
    parameter int NUM_VARS     = 8,
    parameter int NUM_LVLS     = 8,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input logic           clk,
    input logic           rst,
    sat_bin_seq_if.master bus
);
    localparam int CW = $clog2(NUM_CLAUSES);
    typedef enum logic [2:0] {IDLE, LDC, LDV, LDL, STRT, RUN, RDC, FIN} state_t;
    state_t                  state;
    logic [CW-1:0]           idx;
    logic [CW-1:0]           addr;
    logic                    rd_req;
    logic                    mem_wr;
    logic [WIDTH_BIN_ID-1:0] bin;
    logic                    done_bin;
    logic                    sat;
    logic                    unsat;
    logic [WIDTH_LVL-1:0]    bkt;
    logic [NUM_CLAUSES-1:0]  rd_carray;
    logic [NUM_VARS-1:0]     wr_var;
    logic [NUM_LVLS-1:0]     wr_lvl;
    logic                    start_core;
    logic                    base_en;
    logic                    last;
`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           cnt;
    logic                    timeout;
    assign bus.timeout = timeout;
`else
    assign bus.timeout = 1'b0;
`endif
    assign last = idx == CW'(NUM_CLAUSES - 1);
    // clause write must coincide with the memory data, so it follows valid combinationally
    assign bus.eng_wr_carray     = (state == LDC && bus.mem_rd_valid) ? NUM_CLAUSES'(1) << idx : '0;
    assign bus.eng_rd_carray     = rd_carray;
    assign bus.eng_wr_var_states = wr_var;
    assign bus.eng_wr_lvl_states = wr_lvl;
    assign bus.eng_start_core    = start_core;
    assign bus.eng_base_lvl_en   = base_en;
    assign bus.mem_rd_req        = rd_req;
    assign bus.mem_wr            = mem_wr;
    assign bus.mem_addr          = addr;
    assign bus.mem_bin           = bin;
    assign bus.done_bin          = done_bin;
    assign bus.sat               = sat;
    assign bus.unsat             = unsat;
    assign bus.bkt_lvl           = bkt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            addr       <= '0;
            rd_req     <= 1'b0;
            mem_wr     <= 1'b0;
            bin        <= '0;
            done_bin   <= 1'b0;
            sat        <= 1'b0;
            unsat      <= 1'b0;
            bkt        <= '0;
            rd_carray  <= '0;
            wr_var     <= '0;
            wr_lvl     <= '0;
            start_core <= 1'b0;
            base_en    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt        <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start_bin) begin
                    state  <= LDC;
                    idx    <= '0;
                    addr   <= '0;
                    rd_req <= 1'b1;
                    bin    <= bus.bin_id;
                    sat    <= 1'b0;
                    unsat  <= 1'b0;
                    bkt    <= '0;
`ifdef SEQ_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end
                LDC: if (bus.mem_rd_valid) begin
                    if (last) begin
                        state  <= LDV;
                        rd_req <= 1'b0;
                        wr_var <= '1;
                    end else begin
                        idx  <= idx + 1'b1;
                        addr <= idx + 1'b1;
                    end
                end
                LDV: begin
                    state  <= LDL;
                    wr_var <= '0;
                    wr_lvl <= '1;
                end
                LDL: begin
                    state      <= STRT;
                    wr_lvl     <= '0;
                    start_core <= 1'b1;
                    base_en    <= 1'b1;
                end
                STRT: begin
                    state      <= RUN;
                    start_core <= 1'b0;
                    base_en    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                RUN: if (bus.eng_done_core) begin
                    state     <= RDC;
                    sat       <= bus.eng_sat;
                    unsat     <= bus.eng_unsat;
                    bkt       <= bus.eng_bkt_lvl;
                    idx       <= '0;
                    rd_carray <= NUM_CLAUSES'(1);
                end
`ifdef SEQ_TIMEOUT_EN
                // done wins over the watchdog when both land in the same cycle
                else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state    <= FIN;
                    timeout  <= 1'b1;
                    done_bin <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                // clause_o is registered in the engine, so each write trails its read by one cycle
                RDC: begin
                    mem_wr <= 1'b1;
                    addr   <= idx;
                    if (last) begin
                        state     <= FIN;
                        rd_carray <= '0;
                        done_bin  <= 1'b1;
                    end else begin
                        idx       <= idx + 1'b1;
                        rd_carray <= rd_carray << 1;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    mem_wr   <= 1'b0;
                    done_bin <= 1'b0;
                    addr     <= '0;
                    idx      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sat_bin_seq.sv
// tb_sat_bin_seq: randomized self-checking bench for sat_bin_seq against a cycle-timeline model
module tb_sat_bin_seq;
    localparam int N = 8;
`ifdef SEQ_TIMEOUT_EN
    localparam int DMAX = 16;
`else
    localparam int DMAX = 40;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    sat_bin_seq_if bus ();
`ifdef SEQ_TIMEOUT_EN
    sat_bin_seq #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    sat_bin_seq dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    int checks = 0;
    int passed = 0;
    logic       e_req, e_st, e_mw, e_db;
    logic [2:0] e_addr;
    logic [7:0] e_wc, e_rc, e_wv, e_wl;
    logic        x_sat = 1'b0, x_unsat = 1'b0, x_to = 1'b0;
    logic [15:0] x_bkt = '0;
    logic [9:0]  x_bin = '0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    task automatic clear();
        {e_req, e_st, e_mw, e_db} = '0;
        {e_addr, e_wc, e_rc, e_wv, e_wl} = '0;
        bus.start_bin = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.eng_done_core = 1'b0;
        bus.eng_sat = 1'b0;
        bus.eng_unsat = 1'b0;
        bus.eng_bkt_lvl = '0;
    endtask
    // inputs for this cycle are already driven; check the cycle's outputs, then advance
    task automatic tick();
        #1;
        check("rd_req", bus.mem_rd_req, e_req);
        if (e_req || e_mw) check("addr", bus.mem_addr, e_addr);
        check("wr_carray", bus.eng_wr_carray, e_wc);
        check("rd_carray", bus.eng_rd_carray, e_rc);
        check("wr_var", bus.eng_wr_var_states, e_wv);
        check("wr_lvl", bus.eng_wr_lvl_states, e_wl);
        check("start", bus.eng_start_core, e_st);
        check("base_en", bus.eng_base_lvl_en, e_st);
        check("mem_wr", bus.mem_wr, e_mw);
        check("done_bin", bus.done_bin, e_db);
        check("sat", bus.sat, x_sat);
        check("unsat", bus.unsat, x_unsat);
        check("bkt", bus.bkt_lvl, x_bkt);
        check("timeout", bus.timeout, x_to);
        check("mem_bin", bus.mem_bin, x_bin);
        @(negedge clk);
        clear();
    endtask
    task automatic noise();
        bus.mem_rd_valid = 1'($urandom_range(1, 0));
        bus.eng_done_core = 1'($urandom_range(1, 0));
        bus.eng_sat = 1'($urandom_range(1, 0));
        bus.eng_unsat = 1'($urandom_range(1, 0));
        bus.eng_bkt_lvl = 16'($urandom);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            tick();
        end
    endtask
    // one bin: read latency in [lo,hi] per clause, done d cycles after the start pulse
    task automatic run_bin(input logic [9:0] id, input int lo, input int hi, input int d,
                           input logic s, input logic u, input logic [15:0] b,
                           input bit to, input bit poke);
        int dd;
        dd = (d > DMAX) ? DMAX : d;
        bus.start_bin = 1'b1;
        bus.bin_id = id;
        tick();
        x_sat = 1'b0; x_unsat = 1'b0; x_bkt = '0; x_to = 1'b0; x_bin = id;
        for (int k = 0; k < N; k++) begin
            int w;
            w = $urandom_range(hi, lo);
            for (int i = 0; i <= w; i++) begin
                e_req = 1'b1;
                e_addr = 3'(k);
                if (i == w) begin
                    bus.mem_rd_valid = 1'b1;
                    e_wc = 8'(1) << k;
                end
                tick();
            end
        end
        e_wv = 8'hff; tick();
        e_wl = 8'hff; tick();
        e_st = 1'b1; tick();
        for (int i = 1; i <= (to ? 16 : dd); i++) begin
            noise();
            bus.eng_done_core = 1'b0;
            if (poke && i == 1) begin
                bus.start_bin = 1'b1;
                bus.bin_id = ~id;
            end
            if (!to && i == dd) begin
                bus.eng_done_core = 1'b1;
                bus.eng_sat = s;
                bus.eng_unsat = u;
                bus.eng_bkt_lvl = b;
            end
            tick();
        end
        if (!to) begin
            x_sat = s; x_unsat = u; x_bkt = b;
            for (int j = 0; j < N; j++) begin
                noise();
                e_rc = 8'(1) << j;
                if (j > 0) begin
                    e_mw = 1'b1;
                    e_addr = 3'(j - 1);
                end
                tick();
            end
            e_mw = 1'b1;
            e_addr = 3'(N - 1);
        end else begin
            x_to = 1'b1;
        end
        e_db = 1'b1;
        if (poke) begin
            bus.start_bin = 1'b1;
            bus.bin_id = ~id;
        end
        tick();
    endtask
    initial begin
        clear();
        bus.bin_id = '0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        idle(2);
        run_bin(10'd3, 0, 0, 20, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0);
        idle(2);
        run_bin(10'd5, 2, 2, 7, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        idle(4);
        run_bin(10'd9, 0, 3, 5, 1'b1, 1'b0, 16'hbeef, 1'b0, 1'b1);
        run_bin(10'd12, 0, 1, 3, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        bus.start_bin = 1'b1;
        bus.bin_id = 10'h155;
        tick();
        x_sat = 1'b0; x_unsat = 1'b0; x_bkt = '0; x_bin = 10'h155;
        for (int k = 0; k < 4; k++) begin
            e_req = 1'b1;
            e_addr = 3'(k);
            bus.mem_rd_valid = 1'b1;
            e_wc = 8'(1) << k;
            tick();
        end
        bus.mem_rd_valid = 1'b1;
        rst = 1'b0;
        x_bin = '0;
        tick();
        rst = 1'b1;
        idle(1);
        run_bin(10'h2a, 0, 0, 4, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            idle($urandom_range(3, 0));
            run_bin(10'($urandom), 0, 3, $urandom_range(DMAX, 1), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 16'($urandom), 1'b0, 1'($urandom_range(1, 0)));
        end
`ifdef SEQ_TIMEOUT_EN
        idle(1);
        run_bin(10'd7, 0, 1, 0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        idle(2);
`endif
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
